// File: rtl/fifo_pkg.sv
// Shared helpers for the synchronous FIFO: derived widths and the legality test
// applied to every parameter set at elaboration.
package fifo_pkg;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_width(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  function automatic bit params_legal(input int data_w, input int depth,
                                      input int af, input int ae, input int fwft);
    return (data_w >= 1) && (depth >= 2) &&
           (af >= 1) && (af <= depth) &&
           (ae >= 0) && (ae <= depth - 1) &&
           ((fwft == 0) || (fwft == 1));
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// FIFO storage: DEPTH x DATA_W, synchronous write port, asynchronous read port.
// Contents are deliberately not reset.
module fifo_ram #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8,
  parameter int PTR_W  = 3
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [PTR_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [PTR_W-1:0]  rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fifo_sync_param.sv
// Single-clock FIFO with arbitrary depth, almost-full/empty thresholds,
// optional first-word-fall-through reads and a synchronous flush.
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = DEPTH - 1,
  parameter int AE_THRESH = 1,
  parameter int FWFT      = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        wr_en,
  input  logic [DATA_W-1:0]           data_in,
  input  logic                        rd_en,
  output logic [DATA_W-1:0]           data_out,
  output logic                        rd_valid,
  output logic                        wr_ack,
  output logic                        overflow,
  output logic                        underflow,
  output logic                        full,
  output logic                        empty,
  output logic                        almostfull,
  output logic                        almostempty,
  output logic [cnt_width(DEPTH)-1:0] count
);

  localparam int CNT_W = cnt_width(DEPTH);
  localparam int PTR_W = ptr_width(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C     = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] AE_C     = CNT_W'(AE_THRESH);

  generate
    if (!params_legal(DATA_W, DEPTH, AF_THRESH, AE_THRESH, FWFT)) begin : g_illegal
      $error("fifo_sync_param: illegal parameter set");
    end
  endgenerate

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [DATA_W-1:0] head;
  logic              wr_accept;
  logic              rd_accept;

  // Non-power-of-two depths need an explicit wrap rather than binary rollover.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign full        = (count == DEPTH_C);
  assign empty       = (count == '0);
  assign almostfull  = (count >= AF_C);
  assign almostempty = (count <= AE_C);

  assign wr_accept = wr_en && !full && !flush;
  assign rd_accept = rd_en && !empty && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      wr_ack    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      wr_ack    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_accept) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_accept) rd_ptr <= ptr_inc(rd_ptr);
      case ({wr_accept, rd_accept})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      wr_ack    <= wr_accept;
      overflow  <= wr_en && full;
      underflow <= rd_en && empty;
    end
  end

  fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_accept),
    .wr_addr (wr_ptr),
    .wr_data (data_in),
    .rd_addr (rd_ptr),
    .rd_data (head)
  );

  generate
    if (FWFT != 0) begin : g_fwft
      // Head entry is presented directly; rd_en only pops it.
      assign data_out = empty ? '0 : head;
      assign rd_valid = !empty;
    end else begin : g_std
      logic [DATA_W-1:0] data_q;
      logic              valid_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          data_q  <= '0;
          valid_q <= 1'b0;
        end else begin
          valid_q <= rd_accept;
          if (rd_accept) data_q <= head;
        end
      end

      assign data_out = data_q;
      assign rd_valid = valid_q;
    end
  endgenerate

endmodule

// File: tb/tb_fifo_sync_param.sv
// Bench for fifo_sync_param: three configurations (depth 8 registered, depth 5
// registered, depth 8 FWFT) driven against a queue-based reference model.
module tb_fifo_sync_param;

  localparam int N = 3;
  localparam int DEP [N] = '{8, 5, 8};
  localparam int AFT [N] = '{7, 3, 6};
  localparam int AET [N] = '{1, 2, 2};
  localparam bit FW  [N] = '{1'b0, 1'b0, 1'b1};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  initial forever #5 clk = ~clk;

  logic        flush     [N];
  logic        wr_en     [N];
  logic        rd_en     [N];
  logic [15:0] data_in   [N];
  logic [15:0] data_out  [N];
  logic        rd_valid  [N];
  logic        wr_ack    [N];
  logic        overflow  [N];
  logic        underflow [N];
  logic        full      [N];
  logic        empty     [N];
  logic        af        [N];
  logic        ae        [N];
  logic [3:0]  count0;
  logic [2:0]  count1;
  logic [3:0]  count2;

  fifo_sync_param #(.DATA_W(16), .DEPTH(8), .AF_THRESH(7), .AE_THRESH(1), .FWFT(0)) u_d8 (
    .clk(clk), .rst(rst), .flush(flush[0]), .wr_en(wr_en[0]), .data_in(data_in[0]),
    .rd_en(rd_en[0]), .data_out(data_out[0]), .rd_valid(rd_valid[0]), .wr_ack(wr_ack[0]),
    .overflow(overflow[0]), .underflow(underflow[0]), .full(full[0]), .empty(empty[0]),
    .almostfull(af[0]), .almostempty(ae[0]), .count(count0)
  );

  fifo_sync_param #(.DATA_W(16), .DEPTH(5), .AF_THRESH(3), .AE_THRESH(2), .FWFT(0)) u_d5 (
    .clk(clk), .rst(rst), .flush(flush[1]), .wr_en(wr_en[1]), .data_in(data_in[1]),
    .rd_en(rd_en[1]), .data_out(data_out[1]), .rd_valid(rd_valid[1]), .wr_ack(wr_ack[1]),
    .overflow(overflow[1]), .underflow(underflow[1]), .full(full[1]), .empty(empty[1]),
    .almostfull(af[1]), .almostempty(ae[1]), .count(count1)
  );

  fifo_sync_param #(.DATA_W(16), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(2), .FWFT(1)) u_fw (
    .clk(clk), .rst(rst), .flush(flush[2]), .wr_en(wr_en[2]), .data_in(data_in[2]),
    .rd_en(rd_en[2]), .data_out(data_out[2]), .rd_valid(rd_valid[2]), .wr_ack(wr_ack[2]),
    .overflow(overflow[2]), .underflow(underflow[2]), .full(full[2]), .empty(empty[2]),
    .almostfull(af[2]), .almostempty(ae[2]), .count(count2)
  );

  // ---------------- reference model / scoreboard ----------------
  logic [15:0] mdl_q [N][$];   // current FIFO contents, oldest first
  logic [15:0] exp_q [N][$];   // read data expected on rd_valid (registered mode)
  logic        e_ack [N];
  logic        e_ovf [N];
  logic        e_unf [N];
  logic        e_rv  [N];
  logic [15:0] last_out [N];
  int checks   = 0;
  int failures = 0;

  task automatic reset_model();
    for (int i = 0; i < N; i++) begin
      mdl_q[i].delete();
      exp_q[i].delete();
      e_ack[i] = 1'b0;
      e_ovf[i] = 1'b0;
      e_unf[i] = 1'b0;
      e_rv[i]  = 1'b0;
      last_out[i] = 16'h0000;
    end
  endtask

  // Applies one clock edge's worth of requests to the model.
  task automatic update_model();
    for (int i = 0; i < N; i++) begin
      int n;
      bit wa, ra;
      logic [15:0] v;
      n = mdl_q[i].size();
      if (flush[i]) begin
        mdl_q[i].delete();
        e_ack[i] = 1'b0;
        e_ovf[i] = 1'b0;
        e_unf[i] = 1'b0;
        e_rv[i]  = 1'b0;
      end else begin
        wa = wr_en[i] && (n < DEP[i]);
        ra = rd_en[i] && (n > 0);
        e_ack[i] = wa;
        e_ovf[i] = wr_en[i] && !wa;
        e_unf[i] = rd_en[i] && !ra;
        e_rv[i]  = ra && !FW[i];
        if (ra) begin
          v = mdl_q[i].pop_front();
          if (!FW[i]) begin
            exp_q[i].push_back(v);
            last_out[i] = v;
          end
        end
        if (wa) mdl_q[i].push_back(data_in[i]);
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    if (rst) reset_model();
    else update_model();
    #1;
  endtask

  task automatic drive(input int i, input bit w, input bit r, input logic [15:0] d);
    wr_en[i]   = w;
    rd_en[i]   = r;
    data_in[i] = d;
  endtask

  task automatic idle_all();
    for (int i = 0; i < N; i++) begin
      drive(i, 1'b0, 1'b0, 16'h0000);
      flush[i] = 1'b0;
    end
  endtask

  // ---------------- monitor ----------------
  task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] at %0t: got %0h expected %0h", name, i, $time, act, exp);
    end
  endtask

  task automatic mon_inst(input int i, input int cnt);
    int n;
    n = mdl_q[i].size();
    chk("count", i, cnt, n);
    chk("full", i, full[i], n == DEP[i]);
    chk("empty", i, empty[i], n == 0);
    chk("almostfull", i, af[i], n >= AFT[i]);
    chk("almostempty", i, ae[i], n <= AET[i]);
    chk("wr_ack", i, wr_ack[i], e_ack[i]);
    chk("overflow", i, overflow[i], e_ovf[i]);
    chk("underflow", i, underflow[i], e_unf[i]);
    if (!FW[i]) begin
      chk("rd_valid", i, rd_valid[i], e_rv[i]);
      if (rd_valid[i]) begin
        if (exp_q[i].size() == 0) begin
          checks++;
          failures++;
          $display("FAIL read_data[%0d] at %0t: got %0h with no read outstanding", i, $time, data_out[i]);
        end else begin
          chk("read_data", i, data_out[i], exp_q[i].pop_front());
        end
      end else begin
        chk("data_hold", i, data_out[i], last_out[i]);
      end
    end else begin
      chk("fwft_valid", i, rd_valid[i], n > 0);
      if (n > 0) chk("fwft_data", i, data_out[i], mdl_q[i][0]);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      mon_inst(0, int'(count0));
      mon_inst(1, int'(count1));
      mon_inst(2, int'(count2));
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    idle_all();
    rst = 1'b1;
    reset_model();
    repeat (2) step();
    rst = 1'b0;
    step();

    // Fill depth-8 past full, then drain past empty.
    for (int k = 1; k <= 9; k++) begin
      drive(0, 1'b1, 1'b0, 16'(k));
      step();
    end
    for (int k = 0; k < 9; k++) begin
      drive(0, 1'b0, 1'b1, 16'h0000);
      step();
    end
    idle_all();
    step();

    // Simultaneous write+read at full, then at empty.
    for (int k = 0; k < 8; k++) begin
      drive(0, 1'b1, 1'b0, 16'($urandom));
      step();
    end
    drive(0, 1'b1, 1'b1, 16'h5555);
    step();
    for (int k = 0; k < 8; k++) begin
      drive(0, 1'b0, 1'b1, 16'h0000);
      step();
    end
    drive(0, 1'b1, 1'b1, 16'h7777);
    step();
    drive(0, 1'b0, 1'b1, 16'h0000);
    step();
    idle_all();
    step();

    // Depth 5: interleaved traffic wraps the pointers several times.
    for (int k = 0; k < 3; k++) begin
      drive(1, 1'b1, 1'b0, 16'(16'h0100 + k));
      step();
    end
    for (int k = 0; k < 12; k++) begin
      drive(1, 1'b1, 1'b1, 16'(16'h0200 + k));
      step();
    end
    for (int k = 0; k < 4; k++) begin
      drive(1, 1'b0, 1'b1, 16'h0000);
      step();
    end
    idle_all();
    step();

    // FWFT: a single write becomes visible without rd_en.
    drive(2, 1'b1, 1'b0, 16'hABCD);
    step();
    drive(2, 1'b0, 1'b0, 16'h0000);
    repeat (2) step();
    drive(2, 1'b0, 1'b1, 16'h0000);
    step();
    idle_all();
    step();

    // Flush with a write pending at count 4 (one read first so data_out must hold).
    for (int k = 0; k < 5; k++) begin
      drive(0, 1'b1, 1'b0, 16'(16'h0300 + k));
      step();
    end
    drive(0, 1'b0, 1'b1, 16'h0000);
    step();
    flush[0] = 1'b1;
    drive(0, 1'b1, 1'b0, 16'h03FF);
    step();
    idle_all();
    repeat (2) step();

    // Reset in the middle of a burst with reads in flight.
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < N; i++) drive(i, 1'b1, 1'b0, 16'($urandom));
      step();
    end
    for (int i = 0; i < N; i++) drive(i, 1'b1, 1'b1, 16'($urandom));
    step();
    rst = 1'b1;
    reset_model();
    step();
    idle_all();
    step();
    rst = 1'b0;
    step();

    // Randomised traffic, biased towards full, then empty, then balanced.
    for (int c = 0; c < 900; c++) begin
      int wp, rp;
      wp = (c < 300) ? 70 : (c < 600) ? 35 : 55;
      rp = (c < 300) ? 40 : (c < 600) ? 70 : 55;
      for (int i = 0; i < N; i++) begin
        drive(i, $urandom_range(0, 99) < wp, $urandom_range(0, 99) < rp, 16'($urandom));
        flush[i] = ($urandom_range(0, 99) < 2);
      end
      step();
    end
    idle_all();
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
